// File: rtl/bcd_to_binary_seq.sv
// bcd_to_binary_seq: sequential packed-BCD to binary converter (reverse double-dabble)
module bcd_to_binary_seq #(
  parameter int NDIGITS = 9,
  parameter int BIN_W = 30
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [4*NDIGITS-1:0]   bcd_in,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [BIN_W-1:0]       bin_out
);
  localparam int BW = 4 * NDIGITS;
  localparam int CW = $clog2(BIN_W);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state_q, state_d;
  logic [BW-1:0] bcd_sr_q, bcd_sr_d, bcd_sh, bcd_fix;
  logic [BIN_W-1:0] bin_sr_q, bin_sr_d, bin_sh, bin_out_q, bin_out_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic err_pend_q, err_pend_d, err_q, err_d, done_q, done_d, bad, last;
  assign {bcd_sh, bin_sh} = {1'b0, bcd_sr_q, bin_sr_q[BIN_W-1:1]};
  assign last = cnt_q == CW'(BIN_W - 1);
  // A shifted-in bit worth 8 in the lower digit should be worth 5: subtract 3
  always_comb begin
    bcd_fix = bcd_sh;
    bad = 1'b0;
    for (int i = 0; i < NDIGITS; i++) begin
      bcd_fix[4*i+:4] = bcd_sh[4*i+:4] >= 4'd8 ? bcd_sh[4*i+:4] - 4'd3 : bcd_sh[4*i+:4];
      bad = bad | (bcd_in[4*i+:4] > 4'd9);
    end
  end
  always_comb begin
    state_d = state_q;
    bcd_sr_d = bcd_sr_q;
    bin_sr_d = bin_sr_q;
    cnt_d = cnt_q;
    err_pend_d = err_pend_q;
    done_d = 1'b0;
    err_d = err_q;
    bin_out_d = bin_out_q;
    if (state_q == IDLE) begin
      if (start) begin
        state_d = SHIFT;
        bcd_sr_d = bcd_in;
        bin_sr_d = '0;
        cnt_d = '0;
        err_pend_d = bad;
      end
    end else begin
      bcd_sr_d = bcd_fix;
      bin_sr_d = bin_sh;
      cnt_d = cnt_q + 1'b1;
      if (last) begin
        state_d = IDLE;
        done_d = 1'b1;
        err_d = err_pend_q;
        bin_out_d = err_pend_q ? '0 : bin_sh;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      bcd_sr_q <= '0;
      bin_sr_q <= '0;
      cnt_q <= '0;
      err_pend_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      bin_out_q <= '0;
    end else begin
      state_q <= state_d;
      bcd_sr_q <= bcd_sr_d;
      bin_sr_q <= bin_sr_d;
      cnt_q <= cnt_d;
      err_pend_q <= err_pend_d;
      done_q <= done_d;
      err_q <= err_d;
      bin_out_q <= bin_out_d;
    end
  end
  assign busy = state_q == SHIFT;
  assign done = done_q;
  assign err = err_q;
  assign bin_out = bin_out_q;
endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// tb_bcd_to_binary_seq: directed self-checking bench for bcd_to_binary_seq
module tb_bcd_to_binary_seq;
  logic clk = 0, rst = 1, start = 0;
  logic [35:0] bcd_in = '0;
  logic busy, done, err;
  logic [29:0] bin_out;
  int checks = 0, failures = 0;

  bcd_to_binary_seq dut (.clk(clk), .rst(rst), .start(start), .bcd_in(bcd_in),
    .busy(busy), .done(done), .err(err), .bin_out(bin_out));

  always #5 clk = ~clk;

  function automatic logic [35:0] to_bcd(input int v);
    logic [35:0] r = '0;
    int x = v;
    for (int i = 0; i < 9; i++) begin
      r[4*i+:4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_conv(input logic [35:0] v);
    start = 1;
    bcd_in = v;
    tick();
    start = 0;
  endtask

  // Steps until done is seen or a 100-cycle bound expires; n=100 then shows up as a failed latency check.
  task automatic wait_done(output int n, output int bc);
    n = 0;
    bc = 0;
    while (!done && n < 100) begin
      if (busy) bc++;
      tick();
      n++;
    end
  endtask

  task automatic count_dones(input int cycles, output int d);
    d = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (done) d++;
    end
  endtask

  task automatic test_reset();
    rst = 1;
    tick();
    tick();
    rst = 0;
    checks += 4;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
    if (bin_out !== 30'd0) begin failures++; $display("FAIL reset_bin got=%0d exp=0", bin_out); end
  endtask

  task automatic test_zero();
    int n, bc;
    start_conv(36'h000000000);
    wait_done(n, bc);
    checks += 5;
    if (n !== 30) begin failures++; $display("FAIL zero_latency got=%0d exp=30", n); end
    if (bc !== 30) begin failures++; $display("FAIL zero_busy_cycles got=%0d exp=30", bc); end
    if (bin_out !== 30'd0) begin failures++; $display("FAIL zero_bin got=%0d exp=0", bin_out); end
    if (err !== 1'b0) begin failures++; $display("FAIL zero_err got=%b exp=0", err); end
    tick();
    if (done !== 1'b0) begin failures++; $display("FAIL zero_done_pulse got=%b exp=0", done); end
  endtask

  task automatic test_values();
    int n, bc;
    start_conv(36'h999999999);
    wait_done(n, bc);
    checks += 3;
    if (n !== 30) begin failures++; $display("FAIL max_latency got=%0d exp=30", n); end
    if (bin_out !== 30'h3B9AC9FF) begin failures++; $display("FAIL max_bin got=%h exp=3b9ac9ff", bin_out); end
    if (err !== 1'b0) begin failures++; $display("FAIL max_err got=%b exp=0", err); end
    tick();
    start_conv(36'h123456789);
    wait_done(n, bc);
    checks += 2;
    if (bin_out !== 30'h075BCD15) begin failures++; $display("FAIL seq_bin got=%h exp=075bcd15", bin_out); end
    if (err !== 1'b0) begin failures++; $display("FAIL seq_err got=%b exp=0", err); end
  endtask

  task automatic test_invalid();
    int n, bc;
    start_conv(36'h0000A0000);
    wait_done(n, bc);
    checks += 3;
    if (n !== 30) begin failures++; $display("FAIL inv_latency got=%0d exp=30", n); end
    if (err !== 1'b1) begin failures++; $display("FAIL inv_err got=%b exp=1", err); end
    if (bin_out !== 30'd0) begin failures++; $display("FAIL inv_bin got=%0d exp=0", bin_out); end
    tick();
    start_conv(36'h000000127);
    wait_done(n, bc);
    checks += 2;
    if (err !== 1'b0) begin failures++; $display("FAIL after_inv_err got=%b exp=0", err); end
    if (bin_out !== 30'd127) begin failures++; $display("FAIL after_inv_bin got=%0d exp=127", bin_out); end
  endtask

  task automatic test_ignore_busy();
    int n, bc, d;
    start_conv(36'h000000255);
    repeat (4) tick();
    start_conv(36'h000000001);
    wait_done(n, bc);
    checks += 3;
    if (n !== 25) begin failures++; $display("FAIL ign_latency got=%0d exp=25", n); end
    if (bin_out !== 30'd255) begin failures++; $display("FAIL ign_bin got=%0d exp=255", bin_out); end
    count_dones(40, d);
    if (d !== 0) begin failures++; $display("FAIL ign_extra_done got=%0d exp=0", d); end
  endtask

  task automatic test_abort();
    int n, bc, d;
    start_conv(36'h000000999);
    repeat (9) tick();
    rst = 1;
    tick();
    rst = 0;
    checks += 3;
    if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
    if (bin_out !== 30'd0) begin failures++; $display("FAIL abort_bin got=%0d exp=0", bin_out); end
    count_dones(40, d);
    if (d !== 0) begin failures++; $display("FAIL abort_done got=%0d exp=0", d); end
    start_conv(36'h000000042);
    wait_done(n, bc);
    checks += 2;
    if (n !== 30) begin failures++; $display("FAIL abort_new_latency got=%0d exp=30", n); end
    if (bin_out !== 30'd42) begin failures++; $display("FAIL abort_new_bin got=%0d exp=42", bin_out); end
  endtask

  task automatic test_back_to_back();
    int n, bc;
    start = 1;
    bcd_in = to_bcd(0);
    tick();
    bcd_in = to_bcd(1);
    for (int i = 0; i <= 15; i++) begin
      wait_done(n, bc);
      checks += 2;
      if (n !== 30) begin failures++; $display("FAIL b2b_latency[%0d] got=%0d exp=30", i, n); end
      if (bin_out !== 30'(i)) begin failures++; $display("FAIL b2b_bin[%0d] got=%0d exp=%0d", i, bin_out, i); end
      if (i < 15) begin
        tick();
        bcd_in = to_bcd(i + 2);
        if (i == 14) start = 0;
      end
    end
    start = 0;
  endtask

  initial begin
    test_reset();
    test_zero();
    test_values();
    test_invalid();
    test_ignore_busy();
    test_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
